bram_read_arbiter: RTL and testbench

Shares one read-only BRAM port A between two requesters: an AXI4-Lite read slave (port 0, CPU/status access) and a word-addressed request/stream reader (port 1, e.g. a playback or DMA engine). Requests are serviced one at a time. Grants follow a fair round-robin order. The BRAM has a fixed 1-cycle read latency, and each response is held until its consumer accepts it. The block sits between the PS AXI interconnect and the acquisition/playback logic on the shared BRAM port.

---
 rtl/bram_read_arbiter.sv | 138 +++++++++++++
 tb/tb_bram_read_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bram_read_arbiter                                            |
// | Description : Round-robin arbiter sharing one read-only BRAM port between  |
// |               an AXI4-Lite read slave and a word-addressed stream reader.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bram_read_arbiter #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                       aclk,
  input  logic                       areset,

  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,

  input  logic [BRAM_ADDR_WIDTH-1:0] b_req_addr,
  input  logic                       b_req_valid,
  output logic                       b_req_ready,
  output logic [BRAM_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,

  output logic                       busy,

  output logic                       bram_porta_clk,
  output logic                       bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_last_grant;
  logic                       r_grant;
  logic [BRAM_ADDR_WIDTH-1:0] r_addr;
  logic [BRAM_DATA_WIDTH-1:0] r_data;

  logic                       w_grant_any;
  logic                       w_grant_port;
  logic                       w_resp_valid;
  logic                       w_handshake;
  logic                       w_unused_araddr;

  // Bits outside the BRAM word field are intentionally ignored (aliasing).
  assign w_unused_araddr = ^s_axi_araddr;

  // On a tie, the port that did not win last time gets the grant.
  assign w_grant_port = (s_axi_arvalid && b_req_valid) ? ~r_last_grant : b_req_valid;

  assign w_resp_valid = (r_state == ST_RESP) && !areset;
  assign w_handshake  = w_resp_valid && (r_grant ? m_axis_tready : s_axi_rready);

  always_comb begin
    w_state_next = r_state;
    w_grant_any  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!areset && (s_axi_arvalid || b_req_valid)) begin
          w_grant_any  = 1'b1;
          w_state_next = ST_ADDR;
        end
      end
      ST_ADDR: w_state_next = ST_DATA;
      ST_DATA: w_state_next = ST_RESP;
      ST_RESP: begin
        if (w_handshake) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      if (w_grant_any) begin
        r_grant <= w_grant_port;
        r_addr  <= w_grant_port ? b_req_addr
                                : s_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
      end
      // BRAM output is valid in the cycle after ADDR presented the address.
      if (r_state == ST_DATA) begin
        r_data <= bram_porta_rddata;
      end
      if (w_handshake) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign s_axi_arready   = w_grant_any && !w_grant_port;
  assign b_req_ready     = w_grant_any &&  w_grant_port;

  assign s_axi_rvalid    = w_resp_valid && !r_grant;
  assign m_axis_tvalid   = w_resp_valid &&  r_grant;
  assign s_axi_rdata     = r_data;
  assign m_axis_tdata    = r_data;
  assign s_axi_rresp     = 2'b00;

  assign busy            = (r_state != ST_IDLE) && !areset;

  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = areset;
  assign bram_porta_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_bram_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bram_read_arbiter                                         |
// | Description : Self-checking bench for bram_read_arbiter with BRAM model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bram_read_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [9:0]  b_req_addr;
  logic        b_req_valid;
  logic        b_req_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        busy;
  logic        bram_porta_clk;
  logic        bram_porta_rst;
  logic [9:0]  bram_porta_addr;
  logic [31:0] bram_porta_rddata;

  logic [31:0] mem [0:1023];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          model_on = 1'b0;

  // Transaction-level reference state
  bit          m_busy;
  bit          m_port;
  bit          m_last;
  int          m_gcyc;
  logic [31:0] m_exp;
  logic [9:0]  m_addr;
  bit          m_gnt0;
  bit          m_gnt1;

  always #5 aclk = ~aclk;

  always @(posedge aclk) bram_porta_rddata <= mem[bram_porta_addr];

  bram_read_arbiter dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_axi_araddr      (s_axi_araddr),
    .s_axi_arvalid     (s_axi_arvalid),
    .s_axi_arready     (s_axi_arready),
    .s_axi_rdata       (s_axi_rdata),
    .s_axi_rresp       (s_axi_rresp),
    .s_axi_rvalid      (s_axi_rvalid),
    .s_axi_rready      (s_axi_rready),
    .b_req_addr        (b_req_addr),
    .b_req_valid       (b_req_valid),
    .b_req_ready       (b_req_ready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .busy              (busy),
    .bram_porta_clk    (bram_porta_clk),
    .bram_porta_rst    (bram_porta_rst),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_rddata (bram_porta_rddata)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare DUT outputs with the arbitration rules, then advance the model
  // across the coming clock edge.
  task automatic check_cycle();
    bit         gnt, gp, resp, hs;
    logic [9:0] wa;
    m_gnt0 = 1'b0;
    m_gnt1 = 1'b0;
    if (!model_on) return;
    gnt = 1'b0; gp = 1'b0; hs = 1'b0; wa = '0;
    if (!areset && !m_busy && (s_axi_arvalid || b_req_valid)) begin
      gnt = 1'b1;
      gp  = (s_axi_arvalid && b_req_valid) ? !m_last : b_req_valid;
      wa  = gp ? b_req_addr : 10'((s_axi_araddr / 4) % 1024);
    end
    resp = !areset && m_busy && (cyc >= m_gcyc + 3);
    chk1 ("m_arready", s_axi_arready, gnt && !gp);
    chk1 ("m_breq_ready", b_req_ready, gnt && gp);
    chk1 ("m_rvalid", s_axi_rvalid, resp && !m_port);
    chk1 ("m_tvalid", m_axis_tvalid, resp && m_port);
    chk1 ("m_busy", busy, !areset && m_busy);
    chk32("m_rresp", {30'd0, s_axi_rresp}, 32'd0);
    chk10("m_bram_addr", bram_porta_addr, m_addr);
    chk1 ("m_bram_rst", bram_porta_rst, areset);
    if (resp && !m_port) chk32("m_rdata", s_axi_rdata, m_exp);
    if (resp &&  m_port) chk32("m_tdata", m_axis_tdata, m_exp);
    hs = resp && (m_port ? m_axis_tready : s_axi_rready);
    if (areset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_addr = '0;
    end else if (gnt) begin
      m_busy = 1'b1;
      m_port = gp;
      m_gcyc = cyc;
      m_exp  = mem[wa];
      m_addr = wa;
      m_gnt0 = !gp;
      m_gnt1 = gp;
    end else if (hs) begin
      m_busy = 1'b0;
      m_last = m_port;
    end
  endtask

  task automatic tick();
    #1 check_cycle();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_gnt0) s_axi_arvalid = 1'b0;
      if (m_gnt1) b_req_valid   = 1'b0;
    end
  endtask

  task automatic directed_read(input string nm, input bit port, input logic [31:0] addr,
                               input logic [9:0] exp_wa, input logic [31:0] exp_d);
    s_axi_rready  = 1'b1;
    m_axis_tready = 1'b1;
    if (port) begin
      b_req_valid = 1'b1;
      b_req_addr  = addr[9:0];
    end else begin
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = addr;
    end
    #1;
    chk1({nm, "_grant_ready"}, port ? b_req_ready : s_axi_arready, 1'b1);
    chk1({nm, "_other_ready"}, port ? s_axi_arready : b_req_ready, 1'b0);
    tick();
    s_axi_arvalid = 1'b0;
    b_req_valid   = 1'b0;
    chk10({nm, "_bram_addr"}, bram_porta_addr, exp_wa);
    tick();
    #1;
    chk1({nm, "_early_valid"}, port ? m_axis_tvalid : s_axi_rvalid, 1'b0);
    tick();
    #1;
    chk1 ({nm, "_resp_valid"}, port ? m_axis_tvalid : s_axi_rvalid, 1'b1);
    chk1 ({nm, "_other_valid"}, port ? s_axi_rvalid : m_axis_tvalid, 1'b0);
    chk32({nm, "_resp_data"}, port ? m_axis_tdata : s_axi_rdata, exp_d);
    chk32({nm, "_rresp"}, {30'd0, s_axi_rresp}, 32'd0);
    tick();
    #1;
    chk1({nm, "_busy_after"}, busy, 1'b0);
    chk1({nm, "_valid_after"}, port ? m_axis_tvalid : s_axi_rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0] rnd;
    bit          g0, g1;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    mem[5]    = 32'hDEADBEEF;
    mem[1023] = 32'h12345678;

    m_busy = 1'b0; m_port = 1'b0; m_last = 1'b1; m_gcyc = 0;
    m_exp = '0; m_addr = '0;

    areset        = 1'b1;
    s_axi_araddr  = 32'h0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    b_req_addr    = 10'd0;
    b_req_valid   = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    model_on = 1'b1;

    // Reset state, with a request pending that must not be accepted
    s_axi_arvalid = 1'b1;
    b_req_valid   = 1'b1;
    #1;
    chk1 ("rst_arready", s_axi_arready, 1'b0);
    chk1 ("rst_breq_ready", b_req_ready, 1'b0);
    chk1 ("rst_busy", busy, 1'b0);
    chk1 ("rst_rvalid", s_axi_rvalid, 1'b0);
    chk1 ("rst_tvalid", m_axis_tvalid, 1'b0);
    chk10("rst_bram_addr", bram_porta_addr, 10'd0);
    chk32("rst_rdata", s_axi_rdata, 32'd0);
    chk32("rst_tdata", m_axis_tdata, 32'd0);
    tick();
    s_axi_arvalid = 1'b0;
    b_req_valid   = 1'b0;
    areset        = 1'b0;

    directed_read("p0_read", 1'b0, 32'h0000_0014, 10'd5, 32'hDEADBEEF);
    directed_read("p1_top", 1'b1, 32'd1023, 10'd1023, 32'h12345678);
    directed_read("alias", 1'b0, 32'h0000_1014, 10'd5, 32'hDEADBEEF);

    // Continuous requests on both ports from reset
    areset = 1'b1;
    tick();
    areset        = 1'b0;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = $urandom();
    b_req_valid   = 1'b1;
    b_req_addr    = 10'($urandom());
    s_axi_rready  = 1'b1;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk1("rr_arready", s_axi_arready, (k % 8) == 0);
      chk1("rr_breq_ready", b_req_ready, (k % 8) == 4);
      g0 = s_axi_arready;
      g1 = b_req_ready;
      tick();
      if (g0) s_axi_araddr = $urandom();
      if (g1) b_req_addr = 10'($urandom());
    end
    s_axi_arvalid = 1'b0;
    b_req_valid   = 1'b0;
    drain(4);

    // Backpressure on port 0 with port 1 waiting
    areset = 1'b1;
    tick();
    areset        = 1'b0;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = 32'd7 * 4;
    b_req_valid   = 1'b1;
    b_req_addr    = 10'd300;
    s_axi_rready  = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    chk1("bp_arready", s_axi_arready, 1'b1);
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    tick();
    for (int j = 0; j < 10; j++) begin
      #1;
      chk1 ("bp_rvalid_hold", s_axi_rvalid, 1'b1);
      chk32("bp_rdata_hold", s_axi_rdata, mem[7]);
      chk1 ("bp_breq_blocked", b_req_ready, 1'b0);
      tick();
    end
    s_axi_rready = 1'b1;
    #1;
    chk1("bp_breq_at_hs", b_req_ready, 1'b0);
    tick();
    #1;
    chk1("bp_breq_after_hs", b_req_ready, 1'b1);
    chk1("bp_rvalid_after_hs", s_axi_rvalid, 1'b0);
    tick();
    b_req_valid = 1'b0;
    tick();
    tick();
    #1;
    chk1 ("bp_tvalid", m_axis_tvalid, 1'b1);
    chk32("bp_tdata", m_axis_tdata, mem[300]);
    drain(3);

    // Reset during DATA of a port-1 read that follows a port-0 read
    directed_read("pre_rst", 1'b0, 32'h0000_0014, 10'd5, 32'hDEADBEEF);
    b_req_valid = 1'b1;
    b_req_addr  = 10'd50;
    #1;
    chk1("mid_breq_ready", b_req_ready, 1'b1);
    tick();
    b_req_valid = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    chk1 ("mid_rvalid", s_axi_rvalid, 1'b0);
    chk1 ("mid_tvalid", m_axis_tvalid, 1'b0);
    chk1 ("mid_busy", busy, 1'b0);
    chk10("mid_bram_addr", bram_porta_addr, 10'd0);
    chk32("mid_tdata", m_axis_tdata, 32'd0);
    drain(4);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = 32'h20;
    b_req_valid   = 1'b1;
    b_req_addr    = 10'd60;
    #1;
    chk1("mid_tie_arready", s_axi_arready, 1'b1);
    chk1("mid_tie_breq_ready", b_req_ready, 1'b0);
    drain(12);

    // Randomized traffic, backpressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom();
      if (!s_axi_arvalid || m_gnt0) begin
        s_axi_arvalid = rnd[0] | rnd[1];
        s_axi_araddr  = $urandom();
      end
      if (!b_req_valid || m_gnt1) begin
        b_req_valid = rnd[2] | rnd[7];
        b_req_addr  = 10'($urandom());
      end
      s_axi_rready  = rnd[3] | rnd[4];
      m_axis_tready = rnd[5] | rnd[6];
      areset        = (rnd[15:8] == 8'd0);
      tick();
    end
    areset        = 1'b0;
    s_axi_arvalid = 1'b0;
    b_req_valid   = 1'b0;
    s_axi_rready  = 1'b1;
    m_axis_tready = 1'b1;
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
